// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/DM memory port arbiter: response owner tags and strobe-width helper.
package mem_arb_pkg;

  typedef enum logic {OWN_IF, OWN_DM} owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } resp_tag_t;

  localparam int unsigned PERF_W = 32;

  function automatic int unsigned strb_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF port, DM port and memory-macro signals around mem_port_arbiter.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  localparam int unsigned STRB_W = strb_w(DATA_W);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [STRB_W-1:0] dm_wstrb;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_cs;
  logic              mem_we;
  logic [STRB_W-1:0] mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_wstrb, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_cs, mem_we, mem_wstrb, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Pipeline/memory side
  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_wstrb, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_cs, mem_we, mem_wstrb, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arb_resp_pipe.sv
// Fixed-depth shift register of {valid, owner} tags tracking reads in flight to the memory.
module mem_arb_resp_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  resp_tag_t push_tag,
  output resp_tag_t tail_tag
);

  resp_tag_t stage_q [DEPTH];
  resp_tag_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = push_tag;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rst) stage_q[i] <= '0;
      else     stage_q[i] <= stage_d[i];
    end
  end

  assign tail_tag = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: DM priority with an IF starvation guard, fixed-latency read return.
// Optional saturating performance counters when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]   perf_conflict,
  output logic [PERF_W-1:0]   perf_if_stall
`endif
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                if_gnt, dm_gnt;
  resp_tag_t           push_tag, tail_tag;

  always_comb begin
    if_gnt = bus.if_req && (!bus.dm_req || (starve_q == STARVE_W'(STARVE_MAX)));
    dm_gnt = bus.dm_req && !if_gnt;

    // if_req && !if_gnt implies a DM grant, so the count can only move up from here
    starve_d = starve_q;
    if (!bus.if_req || if_gnt) starve_d = '0;
    else if (dm_gnt)           starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

  always_comb begin
    bus.if_gnt    = if_gnt;
    bus.dm_gnt    = dm_gnt;
    bus.mem_cs    = if_gnt || dm_gnt;
    bus.mem_we    = dm_gnt && bus.dm_we;
    bus.mem_wstrb = (dm_gnt && bus.dm_we) ? bus.dm_wstrb : '0;
    bus.mem_addr  = dm_gnt ? bus.dm_addr : bus.if_addr;
    bus.mem_wdata = bus.dm_wdata;
  end

  always_comb begin
    push_tag.valid = if_gnt || (dm_gnt && !bus.dm_we);
    push_tag.owner = dm_gnt ? OWN_DM : OWN_IF;
  end

  mem_arb_resp_pipe #(
    .DEPTH (MEM_LAT)
  ) u_resp_pipe (
    .clk      (clk),
    .rst      (rst),
    .push_tag (push_tag),
    .tail_tag (tail_tag)
  );

  always_comb begin
    bus.if_rvalid = tail_tag.valid && (tail_tag.owner == OWN_IF);
    bus.dm_rvalid = tail_tag.valid && (tail_tag.owner == OWN_DM);
    bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
    bus.dm_rdata  = bus.dm_rvalid ? bus.mem_rdata : '0;
  end

`ifdef ARB_PERF_CNT_EN
  logic [PERF_W-1:0] perf_conflict_q, perf_conflict_d;
  logic [PERF_W-1:0] perf_if_stall_q, perf_if_stall_d;

  always_comb begin
    perf_conflict_d = perf_conflict_q;
    perf_if_stall_d = perf_if_stall_q;
    if (bus.if_req && bus.dm_req && (perf_conflict_q != '1))
      perf_conflict_d = perf_conflict_q + 1'b1;
    if (bus.if_req && !if_gnt && (perf_if_stall_q != '1))
      perf_if_stall_d = perf_if_stall_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict_q <= '0;
      perf_if_stall_q <= '0;
    end else begin
      perf_conflict_q <= perf_conflict_d;
      perf_if_stall_q <= perf_if_stall_d;
    end
  end

  assign perf_conflict = perf_conflict_q;
  assign perf_if_stall = perf_if_stall_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=1 and MEM_LAT=2 instances with behavioural memories.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst1, rst2;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b2 ();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] pc1, ps1, pc2, ps2;
`endif

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk (clk), .rst (rst1), .bus (b1)
`ifdef ARB_PERF_CNT_EN
    , .perf_conflict (pc1), .perf_if_stall (ps1)
`endif
  );

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2), .STARVE_MAX(4)) dut2 (
    .clk (clk), .rst (rst2), .bus (b2)
`ifdef ARB_PERF_CNT_EN
    , .perf_conflict (pc2), .perf_if_stall (ps2)
`endif
  );

  // Behavioural memories; idle read data is a poison pattern so leaks are visible
  localparam logic [63:0] POISON = 64'hBAD0_BAD0_BAD0_BAD0;
  logic [63:0] mem1 [16];
  logic [63:0] mem2 [16];
  logic [63:0] rd1, rd2a, rd2b;

  always @(posedge clk) begin
    if (b1.mem_cs && b1.mem_we)
      for (int b = 0; b < 8; b++)
        if (b1.mem_wstrb[b]) mem1[b1.mem_addr[6:3]][b*8 +: 8] <= b1.mem_wdata[b*8 +: 8];
    rd1 <= (b1.mem_cs && !b1.mem_we) ? mem1[b1.mem_addr[6:3]] : POISON;
  end

  always @(posedge clk) begin
    if (b2.mem_cs && b2.mem_we)
      for (int b = 0; b < 8; b++)
        if (b2.mem_wstrb[b]) mem2[b2.mem_addr[6:3]][b*8 +: 8] <= b2.mem_wdata[b*8 +: 8];
    rd2a <= (b2.mem_cs && !b2.mem_we) ? mem2[b2.mem_addr[6:3]] : POISON;
    rd2b <= rd2a;
  end

  assign b1.mem_rdata = rd1;
  assign b2.mem_rdata = rd2b;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        if_req;
    logic        dm_req;
    logic        dm_we;
    logic [7:0]  dm_wstrb;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;
    logic        e_if_gnt;
    logic        e_dm_gnt;
    logic        e_if_rv;
    logic [63:0] e_if_rd;
    logic        e_dm_rv;
    logic [63:0] e_dm_rd;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic dr, input logic dw, input logic [7:0] ws,
                              input logic [63:0] da, input logic [63:0] wd,
                              input logic eig, input logic edg,
                              input logic eirv, input logic [63:0] eird,
                              input logic edrv, input logic [63:0] edrd);
    vec_t v;
    v.if_req = ir; v.dm_req = dr; v.dm_we = dw; v.dm_wstrb = ws; v.dm_addr = da; v.dm_wdata = wd;
    v.e_if_gnt = eig; v.e_dm_gnt = edg;
    v.e_if_rv = eirv; v.e_if_rd = eird; v.e_dm_rv = edrv; v.e_dm_rd = edrd;
    return v;
  endfunction

  localparam logic [63:0] IF_A   = 64'h1c;
  localparam logic [63:0] WD     = 64'hDEAD_BEEF_CAFE_F00D;
  localparam logic [63:0] MERGED = 64'h1111_2222_CAFE_F00D;

  vec_t vecs [22];

  task automatic idle1();
    b1.if_req = 1'b0; b1.if_addr = IF_A; b1.dm_req = 1'b0; b1.dm_we = 1'b0;
    b1.dm_wstrb = '0; b1.dm_addr = 64'h20; b1.dm_wdata = '0;
  endtask

  task automatic idle2();
    b2.if_req = 1'b0; b2.if_addr = IF_A; b2.dm_req = 1'b0; b2.dm_we = 1'b0;
    b2.dm_wstrb = '0; b2.dm_addr = 64'h20; b2.dm_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem1[i] = 64'h100 + 64'(i);
      mem2[i] = 64'h100 + 64'(i);
    end
    mem1[3] = 64'h13; mem2[3] = 64'h13;
    mem1[4] = 64'h44; mem2[4] = 64'h44;
    mem1[1] = 64'h1111_2222_3333_4444; mem2[1] = 64'h1111_2222_3333_4444;

    // T1: lone fetch; T2: sustained conflict; T3: store/load merge; then starve clear on !if_req
    vecs[0] = mk(0,0,0,8'h00,64'h20,0, 0,0, 0,0, 0,0);
    vecs[1] = mk(1,0,0,8'h00,64'h20,0, 1,0, 0,0, 0,0);
    vecs[2] = mk(0,0,0,8'h00,64'h20,0, 0,0, 1,64'h13, 0,0);
    vecs[3] = mk(1,1,0,8'h00,64'h20,0, 0,1, 0,0, 0,0);
    for (int i = 4; i <= 6; i++) vecs[i] = mk(1,1,0,8'h00,64'h20,0, 0,1, 0,0, 1,64'h44);
    vecs[7] = mk(1,1,0,8'h00,64'h20,0, 1,0, 0,0, 1,64'h44);
    vecs[8] = mk(1,1,0,8'h00,64'h20,0, 0,1, 1,64'h13, 0,0);
    vecs[9] = mk(0,0,0,8'h00,64'h20,0, 0,0, 0,0, 1,64'h44);
    vecs[10] = mk(0,1,1,8'h0F,64'h08,WD, 0,1, 0,0, 0,0);
    vecs[11] = mk(0,1,0,8'h00,64'h08,0, 0,1, 0,0, 0,0);
    vecs[12] = mk(0,0,0,8'h00,64'h20,0, 0,0, 0,0, 1,MERGED);
    vecs[13] = mk(1,1,0,8'h00,64'h20,0, 0,1, 0,0, 0,0);
    vecs[14] = mk(1,1,0,8'h00,64'h20,0, 0,1, 0,0, 1,64'h44);
    vecs[15] = mk(0,1,0,8'h00,64'h20,0, 0,1, 0,0, 1,64'h44);
    for (int i = 16; i <= 19; i++) vecs[i] = mk(1,1,0,8'h00,64'h20,0, 0,1, 0,0, 1,64'h44);
    vecs[20] = mk(1,1,0,8'h00,64'h20,0, 1,0, 0,0, 1,64'h44);
    vecs[21] = mk(0,0,0,8'h00,64'h20,0, 0,0, 1,64'h13, 0,0);

    idle1(); idle2();
    rst1 = 1'b1; rst2 = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_if_rvalid", 64'(b1.if_rvalid), 0);
    chk("rst_dm_rvalid", 64'(b1.dm_rvalid), 0);
    chk("rst_mem_cs", 64'(b1.mem_cs), 0);
    chk("rst_if_rdata", b1.if_rdata, 0);
    chk("rst_dm_rdata", b1.dm_rdata, 0);
    @(posedge clk); #1;
    rst1 = 1'b0; rst2 = 1'b0;

    for (int i = 0; i < 22; i++) begin
      b1.if_req = vecs[i].if_req; b1.if_addr = IF_A;
      b1.dm_req = vecs[i].dm_req; b1.dm_we = vecs[i].dm_we; b1.dm_wstrb = vecs[i].dm_wstrb;
      b1.dm_addr = vecs[i].dm_addr; b1.dm_wdata = vecs[i].dm_wdata;
      @(negedge clk);
      chk($sformatf("v%0d_if_gnt", i), 64'(b1.if_gnt), 64'(vecs[i].e_if_gnt));
      chk($sformatf("v%0d_dm_gnt", i), 64'(b1.dm_gnt), 64'(vecs[i].e_dm_gnt));
      chk($sformatf("v%0d_mem_cs", i), 64'(b1.mem_cs), 64'(vecs[i].e_if_gnt | vecs[i].e_dm_gnt));
      chk($sformatf("v%0d_mem_we", i), 64'(b1.mem_we), 64'(vecs[i].e_dm_gnt & vecs[i].dm_we));
      chk($sformatf("v%0d_mem_wstrb", i), 64'(b1.mem_wstrb),
          (vecs[i].e_dm_gnt && vecs[i].dm_we) ? 64'(vecs[i].dm_wstrb) : 64'h0);
      if (vecs[i].e_if_gnt) chk($sformatf("v%0d_mem_addr", i), b1.mem_addr, IF_A);
      if (vecs[i].e_dm_gnt) chk($sformatf("v%0d_mem_addr", i), b1.mem_addr, vecs[i].dm_addr);
      if (vecs[i].e_dm_gnt && vecs[i].dm_we) chk($sformatf("v%0d_mem_wdata", i), b1.mem_wdata, WD);
      chk($sformatf("v%0d_if_rvalid", i), 64'(b1.if_rvalid), 64'(vecs[i].e_if_rv));
      chk($sformatf("v%0d_if_rdata", i), b1.if_rdata, vecs[i].e_if_rd);
      chk($sformatf("v%0d_dm_rvalid", i), 64'(b1.dm_rvalid), 64'(vecs[i].e_dm_rv));
      chk($sformatf("v%0d_dm_rdata", i), b1.dm_rdata, vecs[i].e_dm_rd);
      @(posedge clk); #1;
    end
    idle1();

`ifdef ARB_PERF_CNT_EN
    begin
      int exp_conf = 0;
      int exp_stall = 0;
      for (int i = 0; i < 22; i++) begin
        if (vecs[i].if_req && vecs[i].dm_req) exp_conf++;
        if (vecs[i].if_req && !vecs[i].e_if_gnt) exp_stall++;
      end
      chk("perf_conflict", 64'(pc1), 64'(exp_conf));
      chk("perf_if_stall", 64'(ps1), 64'(exp_stall));
    end
`endif

    // T4: MEM_LAT=2, IF then DM load back to back
    b2.if_req = 1'b1;
    @(negedge clk);
    chk("t4_if_gnt", 64'(b2.if_gnt), 1);
    next_cycle();
    b2.if_req = 1'b0; b2.dm_req = 1'b1;
    @(negedge clk);
    chk("t4_dm_gnt", 64'(b2.dm_gnt), 1);
    chk("t4_c1_if_rvalid", 64'(b2.if_rvalid), 0);
    next_cycle();
    idle2();
    @(negedge clk);
    chk("t4_c2_if_rvalid", 64'(b2.if_rvalid), 1);
    chk("t4_c2_if_rdata", b2.if_rdata, 64'h13);
    chk("t4_c2_dm_rvalid", 64'(b2.dm_rvalid), 0);
    chk("t4_c2_dm_rdata", b2.dm_rdata, 0);
    next_cycle();
    @(negedge clk);
    chk("t4_c3_dm_rvalid", 64'(b2.dm_rvalid), 1);
    chk("t4_c3_dm_rdata", b2.dm_rdata, 64'h44);
    chk("t4_c3_if_rvalid", 64'(b2.if_rvalid), 0);
    chk("t4_c3_if_rdata", b2.if_rdata, 0);
    next_cycle();

    // T5a: MEM_LAT=2 read in flight is dropped by a one-cycle reset
    b2.if_req = 1'b1;
    next_cycle();
    b2.if_req = 1'b0; rst2 = 1'b1;
    next_cycle();
    rst2 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("t5a_c%0d_if_rvalid", c), 64'(b2.if_rvalid), 0);
      chk($sformatf("t5a_c%0d_dm_rvalid", c), 64'(b2.dm_rvalid), 0);
      next_cycle();
    end

    // T5b: starve count built to 3, reset during an IF grant cycle
    b1.if_req = 1'b1; b1.dm_req = 1'b1;
    for (int c = 0; c < 3; c++) next_cycle();
    b1.dm_req = 1'b0; rst1 = 1'b1;
    next_cycle();
    rst1 = 1'b0; b1.if_req = 1'b0;
    @(negedge clk);
    chk("t5b_if_rvalid", 64'(b1.if_rvalid), 0);
    chk("t5b_dm_rvalid", 64'(b1.dm_rvalid), 0);
    next_cycle();
    b1.if_req = 1'b1; b1.dm_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("t5b_post_dm_gnt%0d", c), 64'(b1.dm_gnt), 1);
      next_cycle();
    end
    b1.dm_req = 1'b0;
    @(negedge clk);
    chk("t5b_first_if_gnt", 64'(b1.if_gnt), 1);
    next_cycle();
    b1.if_req = 1'b0;
    @(negedge clk);
    chk("t5b_first_if_rvalid", 64'(b1.if_rvalid), 1);
    chk("t5b_first_if_rdata", b1.if_rdata, 64'h13);
    chk("t5b_first_dm_rvalid", 64'(b1.dm_rvalid), 0);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
